dcache_store_buffer: RTL
========================

Name: dcache_store_buffer

Overview:
- Responder for the retire stage's store-commit handshake (store_request / store_response) toward the D-cache side.
- Accepts committed stores into a small coalescing FIFO and answers in the same cycle.
- Drains stores in order to memory through a request/accept/ack state machine.
- Provides a load-probe hit so the load unit stalls on same-doubleword addresses that are still pending.

Parameters:
- DEPTH, 4, number of buffered doubleword entries (power of 2, ≥2)
- ADDR_W, 32, byte address width

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (reset==0 clears state at posedge clock)
- store_request  in  1  retire asks to commit the store-queue head store this cycle
- store_addr  in  ADDR_W  byte address of the store
- store_data  in  32  store data, right-aligned
- store_size  in  2  0=byte, 1=half, 2=word (3 is treated as word)
- store_response  out  1  same-cycle acceptance; retire commits only when 1
- mem_req_valid  out  1  write request to memory
- mem_req_addr  out  ADDR_W  doubleword-aligned address (low 3 bits 0)
- mem_req_data  out  64  merged doubleword data
- mem_req_byte_en  out  8  byte enables
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_ack  in  1  memory write completed (1-cycle pulse)
- load_probe_addr  in  ADDR_W  load address to check
- load_probe_hit  out  1  some valid entry matches load_probe_addr[ADDR_W-1:3]
- buffer_empty  out  1  count==0
- buffer_count  out  $clog2(DEPTH+1)  valid entries

Behaviour:
- Reset (reset==0): all entries are invalid, head=tail=count=0, FSM=IDLE. All outputs are 0 except buffer_empty=1. Reset in REQ or WAIT abandons the in-flight write; a later mem_ack is ignored.
- Lane formation:
  - Low address bits are masked to natural alignment.
  - byte: be=1<<a[2:0], data<<8*a[2:0]
  - half: be=3<<{a[2:1],0}
  - word: be=0xF<<{a[2],00}
  - Data is shifted by the same byte offset.
- Merge condition:
  - count≥2, and the youngest entry (tail-1 mod DEPTH) has the same doubleword tag.
  - Bytes are written into that entry and its be is OR-ed with the new be. The newest data wins per byte.
  - The head entry is never merge-targeted.
- Acceptance:
  - store_response = store_request && (merge || count<DEPTH).
  - It is combinational on registered state plus inputs, with no dependence on mem_req_ready or mem_ack.
  - Full (count==DEPTH) with no merge gives response=0, even if a pop occurs in the same cycle.
- On an accepted non-merge push: write entry[tail] with valid=1, tag, data, be; tail++ (wraps at DEPTH); count++.
- Drain FSM:
  - IDLE: if count>0, go to REQ next cycle.
  - REQ: mem_req_valid=1, driven from entry[head] (addr={tag,000}). On mem_req_ready, go to WAIT.
  - WAIT: mem_req_valid=0. On mem_ack, invalidate head, head++ (wraps), count--, and go to IDLE.
  - mem_ack outside WAIT is ignored.
  - Minimum per-entry latency: IDLE→REQ 1 cycle, REQ accept ≥1 cycle, ack ≥1 cycle.
- Push and pop in the same cycle: count is unchanged, head and tail both advance.
- load_probe_hit is combinational over all valid entries, including the head while in REQ or WAIT.
- buffer_count and buffer_empty are registered state.

Test Plan:
- Reset held low 2 cycles mid-WAIT, then released; a stray mem_ack follows → count=0, buffer_empty=1, mem_req_valid=0, no pop.
- Single byte store addr=0x1005, data=0xAB, mem_req_ready=1, ack 2 cycles later:
  - store_response=1 same cycle.
  - mem_req_addr=0x1000, byte_en=0x20, data byte5=0xAB.
  - count returns to 0 after the ack.
- Word stores to 0x2000, then 0x3000, then 0x3004 with memory stalled:
  - Third store merges into the 0x3000 entry, giving be=0xFF and count=2.
  - A word store to 0x2004 afterwards does not merge; count=3.
- Fill 4 distinct doublewords with mem_req_ready=0, then a 5th request → store_response=0 while count==4. Response rises only after the first ack pops an entry.
- Simultaneous accepted push and mem_ack at count=2 → count stays 2, head and tail each advance by 1, wrap verified past index 3.
- load_probe_addr=0x3006 with 0x3000 pending → load_probe_hit=1; probe at 0x3008 → 0.

Source files
------------

// File: rtl/dcache_store_buffer_if.sv
// Store-commit handshake from retire and the write port toward memory.
// The buffer sits on the slave side; retire plus memory form the master side.
interface dcache_store_buffer_if #(
   parameter int ADDR_W = 32
);
   logic              store_request;
   logic [ADDR_W-1:0] store_addr;
   logic [31:0]       store_data;
   logic [1:0]        store_size;
   logic              store_response;
   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [63:0]       mem_req_data;
   logic [7:0]        mem_req_byte_en;
   logic              mem_req_ready;
   logic              mem_ack;

   modport master (
      output store_request, store_addr, store_data, store_size,
      input  store_response,
      input  mem_req_valid, mem_req_addr, mem_req_data, mem_req_byte_en,
      output mem_req_ready, mem_ack
   );

   modport slave (
      input  store_request, store_addr, store_data, store_size,
      output store_response,
      output mem_req_valid, mem_req_addr, mem_req_data, mem_req_byte_en,
      input  mem_req_ready, mem_ack
   );
endinterface

// File: rtl/dcache_store_buffer.sv
// Coalescing store buffer between retire and the D-cache write port.
// Stores drain in order; same-doubleword loads see a probe hit meanwhile.
module dcache_store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
) (
   input  logic                       clock,
   input  logic                       reset,
   dcache_store_buffer_if.slave       bus,
   input  logic [ADDR_W-1:0]          load_probe_addr,
   output logic                       load_probe_hit,
   output logic                       buffer_empty,
   output logic [$clog2(DEPTH+1)-1:0] buffer_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int TW = ADDR_W - 3;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t          state;
   logic [DEPTH-1:0] valid_q;
   logic [TW-1:0]   tag_q  [DEPTH];
   logic [63:0]     data_q [DEPTH];
   logic [7:0]      be_q   [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [PW-1:0]   yng;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nx;
   logic            empty_q;
   logic            req_valid;

   logic [2:0]      off;
   logic [7:0]      lane_be;
   logic [63:0]     shifted;
   logic [63:0]     lane_data;
   logic [TW-1:0]   st_tag;
   logic            merge;
   logic            accept;
   logic            push;
   logic            pop;
   logic            probe_unused;

   assign st_tag = bus.store_addr[ADDR_W-1:3];
   assign yng    = tail - 1'b1;

   // Offset is forced to natural alignment before shifting lanes
   always_comb begin
      off     = bus.store_addr[2:0];
      lane_be = 8'h00;
      unique case (1'b1)
         (bus.store_size == 2'd0): begin
            lane_be = 8'h01 << off;
         end
         (bus.store_size == 2'd1): begin
            off[0]  = 1'b0;
            lane_be = 8'h03 << off;
         end
         default: begin
            off[1:0] = 2'b00;
            lane_be  = 8'h0F << off;
         end
      endcase
      shifted   = {32'h0, bus.store_data} << {off, 3'b000};
      lane_data = '0;
      for (int i = 0; i < 8; i++) begin
         lane_data[8*i +: 8] = lane_be[i] ? shifted[8*i +: 8] : 8'h00;
      end
   end

   // count>=2 keeps the head (possibly in flight) out of merge reach
   assign merge  = (count >= CW'(2)) && valid_q[yng] && (tag_q[yng] == st_tag);
   assign accept = bus.store_request && (merge || (count != CW'(DEPTH)));
   assign push   = accept && !merge;
   assign pop    = (state == WAIT) && bus.mem_ack;

   always_comb begin
      unique case ({push, pop})
         2'b10:   count_nx = count + CW'(1);
         2'b01:   count_nx = count - CW'(1);
         default: count_nx = count;
      endcase
   end

   always_comb begin
      load_probe_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && (tag_q[i] == load_probe_addr[ADDR_W-1:3])) begin
            load_probe_hit = 1'b1;
         end
      end
   end

   assign probe_unused = ^load_probe_addr[2:0];

   assign bus.store_response  = accept;
   assign bus.mem_req_valid   = req_valid;
   assign bus.mem_req_addr    = {tag_q[head], 3'b000};
   assign bus.mem_req_data    = data_q[head];
   assign bus.mem_req_byte_en = be_q[head];
   assign buffer_count        = count;
   assign buffer_empty        = empty_q;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         empty_q   <= 1'b1;
         req_valid <= 1'b0;
         valid_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
            be_q[i]   <= '0;
         end
      end else begin
         if (push) begin
            valid_q[tail] <= 1'b1;
            tag_q[tail]   <= st_tag;
            data_q[tail]  <= lane_data;
            be_q[tail]    <= lane_be;
            tail          <= tail + 1'b1;
         end
         if (accept && merge) begin
            for (int b = 0; b < 8; b++) begin
               if (lane_be[b]) data_q[yng][8*b +: 8] <= lane_data[8*b +: 8];
            end
            be_q[yng] <= be_q[yng] | lane_be;
         end
         if (pop) begin
            valid_q[head] <= 1'b0;
            head          <= head + 1'b1;
         end
         count   <= count_nx;
         empty_q <= (count_nx == '0);
         unique case (state)
            IDLE: begin
               if (count != '0) begin
                  state     <= REQ;
                  req_valid <= 1'b1;
               end
            end
            REQ: begin
               if (bus.mem_req_ready) begin
                  state     <= WAIT;
                  req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.mem_ack) state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               req_valid <= 1'b0;
            end
         endcase
      end
   end
endmodule
